// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and its stall/flush sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             DCacheMiss;
  logic             DCacheReady;
  logic             BranchE;
  logic             BrTakenE;
  logic             PredTakenE;
  logic             JalrE;
  logic             MemToRegE;
  logic [4:0]       RdE;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [1:0]       RegReadD;

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic             StallM;
  logic             FlushM;
  logic             StallW;
  logic             FlushW;
  logic             RedirectE;
  logic [CNT_W-1:0] MispredCnt;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output DCacheMiss, DCacheReady, BranchE, BrTakenE, PredTakenE, JalrE, MemToRegE,
    output RdE, Rs1D, Rs2D, RegReadD,
    input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
    input  RedirectE, MispredCnt, StallCnt
  );

  modport slave (
    input  DCacheMiss, DCacheReady, BranchE, BrTakenE, PredTakenE, JalrE, MemToRegE,
    input  RdE, Rs1D, Rs2D, RegReadD,
    output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
    output RedirectE, MispredCnt, StallCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: D-cache miss stalls, mispredict redirects, load-use bubbles,
// plus saturating perf counters for mispredicts and front-end stall cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MISS_DRAIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned DrainW = (MISS_DRAIN > 1) ? $clog2(MISS_DRAIN) : 1;

  typedef enum logic [1:0] {StRun, StMiss, StDrain} state_e;

  state_e              state_q;
  logic [DrainW-1:0]   drain_cnt_q;
  logic [CNT_W-1:0]    mispred_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic mispred;
  logic load_use;
  logic miss_pending;

  logic stall_f, stall_d, flush_d, stall_e, flush_e;
  logic stall_m, flush_m, stall_w, flush_w, redirect_e;

  assign mispred = (hz.BranchE & (hz.BrTakenE ^ hz.PredTakenE)) | hz.JalrE;

  assign load_use = hz.MemToRegE && (hz.RdE != 5'd0) &&
                    ((hz.RegReadD[1] && (hz.RdE == hz.Rs1D)) ||
                     (hz.RegReadD[0] && (hz.RdE == hz.Rs2D)));

  // A miss that completes in the same cycle is effectively a hit.
  assign miss_pending = hz.DCacheMiss & ~hz.DCacheReady;

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    stall_e    = 1'b0;
    flush_e    = 1'b0;
    stall_m    = 1'b0;
    flush_m    = 1'b0;
    stall_w    = 1'b0;
    flush_w    = 1'b0;
    redirect_e = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (miss_pending) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
          end else if (mispred) begin
            redirect_e = 1'b1;
            flush_d    = 1'b1;
            flush_e    = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        StMiss: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          // On refill MEM-WB is released so it captures the returned data.
          stall_m = ~hz.DCacheReady;
          flush_w = ~hz.DCacheReady;
        end
        StDrain: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      drain_cnt_q   <= '0;
      mispred_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (miss_pending) state_q <= StMiss;
        end
        StMiss: begin
          if (hz.DCacheReady) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainW'(MISS_DRAIN - 1);
          end
        end
        StDrain: begin
          if (drain_cnt_q == '0) begin
            state_q <= StRun;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase

      if (redirect_e && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      if (stall_f && (stall_cnt_q != '1))      stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.StallE     = stall_e;
  assign hz.FlushE     = flush_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushM     = flush_m;
  assign hz.StallW     = stall_w;
  assign hz.FlushW     = flush_w;
  assign hz.RedirectE  = redirect_e;
  assign hz.MispredCnt = mispred_cnt_q;
  assign hz.StallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, mispredict, miss sequencing,
// mispredict held across a miss, and counter saturation on a narrow-counter instance.
module tb_pipeline_hazard_ctrl;

  // Output vector order: StallF StallD FlushD StallE FlushE StallM FlushM StallW FlushW RedirectE
  localparam logic [9:0] OutIdle   = 10'b00_0_00_00_00_0;
  localparam logic [9:0] OutMiss   = 10'b11_0_10_10_01_0;
  localparam logic [9:0] OutRefill = 10'b11_0_10_00_00_0;
  localparam logic [9:0] OutDrain  = 10'b11_0_10_01_00_0;
  localparam logic [9:0] OutMisp   = 10'b00_1_01_00_00_1;
  localparam logic [9:0] OutLdUse  = 10'b11_0_01_00_00_0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_mis;
  logic [31:0] exp_stall;
  logic [9:0]  outs;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  sbus ();

  pipeline_hazard_ctrl #(.CNT_W(32), .MISS_DRAIN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MISS_DRAIN(1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (sbus)
  );

  assign outs = {bus.StallF, bus.StallD, bus.FlushD, bus.StallE, bus.FlushE,
                 bus.StallM, bus.FlushM, bus.StallW, bus.FlushW, bus.RedirectE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    bus.DCacheMiss  = 1'b0;
    bus.DCacheReady = 1'b0;
    bus.BranchE     = 1'b0;
    bus.BrTakenE    = 1'b0;
    bus.PredTakenE  = 1'b0;
    bus.JalrE       = 1'b0;
    bus.MemToRegE   = 1'b0;
    bus.RdE         = 5'd0;
    bus.Rs1D        = 5'd0;
    bus.Rs2D        = 5'd0;
    bus.RegReadD    = 2'b00;
  endtask

  task automatic set_sat_idle();
    sbus.DCacheMiss  = 1'b0;
    sbus.DCacheReady = 1'b0;
    sbus.BranchE     = 1'b0;
    sbus.BrTakenE    = 1'b0;
    sbus.PredTakenE  = 1'b0;
    sbus.JalrE       = 1'b0;
    sbus.MemToRegE   = 1'b0;
    sbus.RdE         = 5'd0;
    sbus.Rs1D        = 5'd0;
    sbus.Rs2D        = 5'd0;
    sbus.RegReadD    = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_idle();
    set_sat_idle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, OutIdle);
    end
    checks++;
    if (bus.StallCnt !== 32'd0 || bus.MispredCnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.StallCnt, bus.MispredCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.DCacheMiss = 1'b1;
    #1;
    checks++;
    if (outs !== OutMiss) begin
      errors++; $display("FAIL reset_enter_miss: got %b expected %b", outs, OutMiss);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs !== OutMiss) begin
      errors++; $display("FAIL reset_in_miss: got %b expected %b", outs, OutMiss);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL reset_async_outs: got %b expected %b", outs, OutIdle);
    end
    checks++;
    if (bus.StallCnt !== 32'd0 || bus.MispredCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_async_cnt: got %0d/%0d expected 0/0", bus.StallCnt, bus.MispredCnt);
    end
    // Ready alone would release MEM in MISS; in RUN it must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    bus.DCacheMiss  = 1'b0;
    bus.DCacheReady = 1'b1;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL reset_to_run: got %b expected %b", outs, OutIdle);
    end
    @(negedge clk);
    bus.DCacheReady = 1'b0;
    #1;
    checks++;
    if (bus.StallCnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt_after: got %0d expected 0", bus.StallCnt);
    end
    exp_mis   = 32'd0;
    exp_stall = 32'd0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    bus.MemToRegE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5; bus.Rs2D = 5'd0;
    bus.RegReadD = 2'b10;
    #1;
    checks++;
    if (outs !== OutLdUse) begin
      errors++; $display("FAIL lu_rs1: got %b expected %b", outs, OutLdUse);
    end
    exp_stall++;
    @(negedge clk);
    bus.Rs1D = 5'd3; bus.Rs2D = 5'd5; bus.RegReadD = 2'b01;
    #1;
    checks++;
    if (outs !== OutLdUse) begin
      errors++; $display("FAIL lu_rs2: got %b expected %b", outs, OutLdUse);
    end
    exp_stall++;
    @(negedge clk);
    bus.RegReadD = 2'b10;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL lu_unused_src: got %b expected %b", outs, OutIdle);
    end
    @(negedge clk);
    bus.RdE = 5'd0; bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.RegReadD = 2'b11;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL lu_x0: got %b expected %b", outs, OutIdle);
    end
    @(negedge clk);
    bus.MemToRegE = 1'b0; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL lu_not_load: got %b expected %b", outs, OutIdle);
    end
    checks++;
    if (bus.StallCnt !== exp_stall) begin
      errors++; $display("FAIL lu_stallcnt: got %0d expected %0d", bus.StallCnt, exp_stall);
    end
    set_idle();
  endtask

  task automatic test_mispredict();
    @(negedge clk);
    bus.BranchE = 1'b1; bus.BrTakenE = 1'b1; bus.PredTakenE = 1'b0;
    bus.MemToRegE = 1'b1; bus.RdE = 5'd7; bus.Rs1D = 5'd7; bus.RegReadD = 2'b10;
    #1;
    checks++;
    if (outs !== OutMisp) begin
      errors++; $display("FAIL mp_beats_lu: got %b expected %b", outs, OutMisp);
    end
    exp_mis++;
    @(negedge clk);
    bus.PredTakenE = 1'b1;
    #1;
    checks++;
    if (outs !== OutLdUse) begin
      errors++; $display("FAIL mp_correct_pred: got %b expected %b", outs, OutLdUse);
    end
    checks++;
    if (bus.MispredCnt !== 32'd1) begin
      errors++; $display("FAIL mp_cnt1: got %0d expected 1", bus.MispredCnt);
    end
    exp_stall++;
    @(negedge clk);
    set_idle();
    bus.BranchE = 1'b0; bus.BrTakenE = 1'b1; bus.PredTakenE = 1'b0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL mp_not_branch: got %b expected %b", outs, OutIdle);
    end
    @(negedge clk);
    bus.BranchE = 1'b1; bus.BrTakenE = 1'b0; bus.PredTakenE = 1'b1;
    #1;
    checks++;
    if (outs !== OutMisp) begin
      errors++; $display("FAIL mp_pred_taken_not: got %b expected %b", outs, OutMisp);
    end
    exp_mis++;
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (bus.MispredCnt !== exp_mis || bus.StallCnt !== exp_stall) begin
      errors++; $display("FAIL mp_counters: got %0d/%0d expected %0d/%0d",
                         bus.MispredCnt, bus.StallCnt, exp_mis, exp_stall);
    end
  endtask

  task automatic test_miss();
    @(negedge clk);
    bus.DCacheMiss = 1'b1; bus.DCacheReady = 1'b1;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL miss_hit_same_cycle: got %b expected %b", outs, OutIdle);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.DCacheMiss = 1'b1; bus.DCacheReady = 1'b0;
      #1;
      checks++;
      if (outs !== OutMiss) begin
        errors++; $display("FAIL miss_stall[%0d]: got %b expected %b", i, outs, OutMiss);
      end
      exp_stall++;
    end
    @(negedge clk);
    bus.DCacheReady = 1'b1;
    #1;
    checks++;
    if (outs !== OutRefill) begin
      errors++; $display("FAIL miss_refill: got %b expected %b", outs, OutRefill);
    end
    exp_stall++;
    @(negedge clk);
    bus.DCacheMiss = 1'b0; bus.DCacheReady = 1'b0;
    #1;
    checks++;
    if (outs !== OutDrain) begin
      errors++; $display("FAIL miss_drain: got %b expected %b", outs, OutDrain);
    end
    exp_stall++;
    @(negedge clk);
    bus.DCacheReady = 1'b1;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL miss_back_to_run: got %b expected %b", outs, OutIdle);
    end
    checks++;
    if (bus.StallCnt !== exp_stall) begin
      errors++; $display("FAIL miss_stallcnt: got %0d expected %0d", bus.StallCnt, exp_stall);
    end
    set_idle();
  endtask

  task automatic test_miss_mispred();
    @(negedge clk);
    bus.JalrE = 1'b1; bus.DCacheMiss = 1'b1;
    #1;
    checks++;
    if (outs !== OutMiss) begin
      errors++; $display("FAIL mm_enter: got %b expected %b", outs, OutMiss);
    end
    exp_stall++;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== OutMiss) begin
      errors++; $display("FAIL mm_miss: got %b expected %b", outs, OutMiss);
    end
    exp_stall++;
    @(negedge clk);
    bus.DCacheReady = 1'b1;
    #1;
    checks++;
    if (outs !== OutRefill) begin
      errors++; $display("FAIL mm_refill: got %b expected %b", outs, OutRefill);
    end
    exp_stall++;
    @(negedge clk);
    bus.DCacheMiss = 1'b0; bus.DCacheReady = 1'b0;
    #1;
    checks++;
    if (outs !== OutDrain) begin
      errors++; $display("FAIL mm_drain: got %b expected %b", outs, OutDrain);
    end
    exp_stall++;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== OutMisp) begin
      errors++; $display("FAIL mm_redirect: got %b expected %b", outs, OutMisp);
    end
    exp_mis++;
    @(negedge clk);
    bus.JalrE = 1'b0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++; $display("FAIL mm_after: got %b expected %b", outs, OutIdle);
    end
    checks++;
    if (bus.MispredCnt !== exp_mis || bus.StallCnt !== exp_stall) begin
      errors++; $display("FAIL mm_counters: got %0d/%0d expected %0d/%0d",
                         bus.MispredCnt, bus.StallCnt, exp_mis, exp_stall);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] exp_sat;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sbus.BranchE = 1'b1; sbus.BrTakenE = 1'b0; sbus.PredTakenE = 1'b1;
      #1;
      exp_sat = (i < 7) ? 3'(i) : 3'd7;
      checks++;
      if (sbus.RedirectE !== 1'b1 || sbus.MispredCnt !== exp_sat) begin
        errors++; $display("FAIL sat[%0d]: got redirect=%b cnt=%0d expected redirect=1 cnt=%0d",
                           i, sbus.RedirectE, sbus.MispredCnt, exp_sat);
      end
    end
    @(negedge clk);
    set_sat_idle();
    #1;
    checks++;
    if (sbus.MispredCnt !== 3'd7 || sbus.StallCnt !== 3'd0) begin
      errors++; $display("FAIL sat_final: got %0d/%0d expected 7/0",
                         sbus.MispredCnt, sbus.StallCnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_mispredict();
    test_miss();
    test_miss_mispred();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
